// File: rtl/dual_port_mem_responder.sv
// Fixed-latency memory responder shared by the instruction and data ports.
// One single-ported 16-bit word array; round-robin arbitration between ports.
module dual_port_mem_responder #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  input  logic [15:0] imem_address,
  input  logic [15:0] imem_wdata,
  input  logic        imem_read,
  input  logic        imem_write,
  input  logic [1:0]  imem_byte_enable,
  output logic [15:0] imem_rdata,
  output logic        imem_resp
);

  localparam int unsigned Words   = 1 << ADDR_BITS;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  logic [15:0]          mem_q [Words];
  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 last_dmem_q, gnt_dmem_q, op_write_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [15:0]          wdata_q;
  logic [1:0]           be_q;
  logic                 mem_resp_q, imem_resp_q;
  logic [15:0]          mem_rdata_q, imem_rdata_q;

  logic                 d_pend, i_pend, any_pend, pick_dmem, sel_write;
  logic [15:0]          sel_addr, sel_wdata;
  logic [1:0]           sel_be;
  logic [ADDR_BITS-1:0] sel_idx;
  logic                 enter_resp, resp_dmem, resp_write;
  logic [ADDR_BITS-1:0] resp_idx;
  logic                 wr_commit;
  logic                 unused_addr;

  assign d_pend    = mem_read | mem_write;
  assign i_pend    = imem_read | imem_write;
  assign any_pend  = d_pend | i_pend;
  // On a tie the port that did not win last time is served.
  assign pick_dmem = d_pend & (~i_pend | ~last_dmem_q);
  assign sel_addr  = pick_dmem ? mem_address : imem_address;
  assign sel_wdata = pick_dmem ? mem_wdata : imem_wdata;
  assign sel_be    = pick_dmem ? mem_byte_enable : imem_byte_enable;
  assign sel_write = pick_dmem ? mem_write : imem_write;
  assign sel_idx   = sel_addr[ADDR_BITS:1];

  assign unused_addr = ^{mem_address, imem_address};

  // With LATENCY=1 the response is set up straight from the grant.
  always_comb begin
    enter_resp = 1'b0;
    resp_dmem  = gnt_dmem_q;
    resp_write = op_write_q;
    resp_idx   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (any_pend && (LATENCY == 1)) begin
          enter_resp = 1'b1;
          resp_dmem  = pick_dmem;
          resp_write = sel_write;
          resp_idx   = sel_idx;
        end
      end
      StBusy:  enter_resp = (cnt_q == 4'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_dmem_q  <= 1'b0;
      gnt_dmem_q   <= 1'b0;
      op_write_q   <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      mem_resp_q   <= 1'b0;
      imem_resp_q  <= 1'b0;
      mem_rdata_q  <= '0;
      imem_rdata_q <= '0;
    end else begin
      mem_resp_q  <= 1'b0;
      imem_resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_pend) begin
            gnt_dmem_q  <= pick_dmem;
            last_dmem_q <= pick_dmem;
            op_write_q  <= sel_write;
            idx_q       <= sel_idx;
            wdata_q     <= sel_wdata;
            be_q        <= sel_be;
            cnt_q       <= CntInit;
            state_q     <= StBusy;
          end
        end
        StBusy:  cnt_q   <= cnt_q - 4'd1;
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (enter_resp) begin
        state_q <= StResp;
        if (resp_dmem) mem_resp_q <= 1'b1;
        else           imem_resp_q <= 1'b1;
        if (!resp_write) begin
          if (resp_dmem) mem_rdata_q  <= mem_q[resp_idx];
          else           imem_rdata_q <= mem_q[resp_idx];
        end
      end
    end
  end

  // Writes commit at the edge that ends the response cycle; a reset before then drops them.
  assign wr_commit = (state_q == StResp) && op_write_q;

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
      if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
    end
  end

  assign mem_resp   = mem_resp_q;
  assign imem_resp  = imem_resp_q;
  assign mem_rdata  = mem_rdata_q;
  assign imem_rdata = imem_rdata_q;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Scoreboard bench: LATENCY=2 instance under directed and random traffic,
// plus a LATENCY=1 instance for held back-to-back reads.
module tb_dual_port_mem_responder;

  localparam int Lat = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_byte_enable;
  logic [15:0] imem_address, imem_wdata, imem_rdata;
  logic        imem_read, imem_write, imem_resp;
  logic [1:0]  imem_byte_enable;

  logic [15:0] b_mem_address, b_mem_wdata, b_mem_rdata;
  logic        b_mem_read, b_mem_write, b_mem_resp;
  logic [1:0]  b_mem_byte_enable;
  logic [15:0] b_imem_address, b_imem_wdata, b_imem_rdata;
  logic        b_imem_read, b_imem_write, b_imem_resp;
  logic [1:0]  b_imem_byte_enable;

  dual_port_mem_responder #(.ADDR_BITS(12), .LATENCY(Lat), .INIT_FILE("")) u_dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .imem_address(imem_address), .imem_wdata(imem_wdata), .imem_read(imem_read),
    .imem_write(imem_write), .imem_byte_enable(imem_byte_enable),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp)
  );

  dual_port_mem_responder #(.ADDR_BITS(12), .LATENCY(1), .INIT_FILE("")) u_dut_l1 (
    .clk(clk), .reset(reset),
    .mem_address(b_mem_address), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_byte_enable(b_mem_byte_enable),
    .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp),
    .imem_address(b_imem_address), .imem_wdata(b_imem_wdata), .imem_read(b_imem_read),
    .imem_write(b_imem_write), .imem_byte_enable(b_imem_byte_enable),
    .imem_rdata(b_imem_rdata), .imem_resp(b_imem_resp)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model: word store by index, last read data per port, last granted port.
  logic [15:0] model_mem [int];
  logic [15:0] m_rd_d = 16'h0000;
  logic [15:0] m_rd_i = 16'h0000;
  bit          m_last_d = 1'b0;

  logic [15:0] q_d_data[$];
  int          q_d_cyc[$];
  logic [15:0] q_i_data[$];
  int          q_i_cyc[$];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic void model_apply(input bit port_d, input bit wr, input logic [15:0] addr,
                                      input logic [15:0] wdata, input logic [1:0] be,
                                      input int due);
    int          idx;
    logic [15:0] w;
    idx = int'(addr[12:1]);
    w   = model_mem.exists(idx) ? model_mem[idx] : 16'h0000;
    if (wr) begin
      if (be[1]) w[15:8] = wdata[15:8];
      if (be[0]) w[7:0]  = wdata[7:0];
      model_mem[idx] = w;
    end else if (port_d) begin
      m_rd_d = w;
    end else begin
      m_rd_i = w;
    end
    if (port_d) begin
      q_d_data.push_back(m_rd_d);
      q_d_cyc.push_back(due);
    end else begin
      q_i_data.push_back(m_rd_i);
      q_i_cyc.push_back(due);
    end
  endfunction

  task automatic check_pop(input bit port_d, input logic [15:0] data);
    logic [15:0] e;
    int          c;
    total++;
    if (port_d ? (q_d_data.size() == 0) : (q_i_data.size() == 0)) begin
      bad++;
      $display("FAIL unexpected_resp port_d=%0d: got resp at cycle %0d want none", port_d, cyc);
    end else begin
      if (port_d) begin
        e = q_d_data.pop_front();
        c = q_d_cyc.pop_front();
      end else begin
        e = q_i_data.pop_front();
        c = q_i_cyc.pop_front();
      end
      if (data !== e || cyc != c) begin
        bad++;
        $display("FAIL resp port_d=%0d: got data %h cycle %0d want data %h cycle %0d",
                 port_d, data, cyc, e, c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mem_resp)  check_pop(1'b1, mem_rdata);
    if (imem_resp) check_pop(1'b0, imem_rdata);
  end

  task automatic drive(input bit port_d, input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be);
    bit seen;
    seen = 1'b0;
    if (port_d) begin
      mem_address = addr; mem_wdata = wdata; mem_byte_enable = be;
      mem_read = rd; mem_write = wr;
    end else begin
      imem_address = addr; imem_wdata = wdata; imem_byte_enable = be;
      imem_read = rd; imem_write = wr;
    end
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = port_d ? mem_resp : imem_resp;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout port_d=%0d: got resp 0 want 1", port_d);
    end
    @(posedge clk);
    #1;
    if (port_d) begin mem_read = 1'b0; mem_write = 1'b0; end
    else begin imem_read = 1'b0; imem_write = 1'b0; end
  endtask

  task automatic issue1(input bit port_d, input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be);
    model_apply(port_d, wr, addr, wdata, be, cyc + Lat);
    m_last_d = port_d;
    drive(port_d, rd, wr, addr, wdata, be);
  endtask

  task automatic issue2(input bit drd, input bit dwr, input logic [15:0] daddr,
                        input logic [15:0] dwdata, input logic [1:0] dbe,
                        input bit ird, input bit iwr, input logic [15:0] iaddr,
                        input logic [15:0] iwdata, input logic [1:0] ibe);
    if (!m_last_d) begin
      model_apply(1'b1, dwr, daddr, dwdata, dbe, cyc + Lat);
      model_apply(1'b0, iwr, iaddr, iwdata, ibe, cyc + 2 * Lat + 1);
      m_last_d = 1'b0;
    end else begin
      model_apply(1'b0, iwr, iaddr, iwdata, ibe, cyc + Lat);
      model_apply(1'b1, dwr, daddr, dwdata, dbe, cyc + 2 * Lat + 1);
      m_last_d = 1'b1;
    end
    fork
      drive(1'b1, drd, dwr, daddr, dwdata, dbe);
      drive(1'b0, ird, iwr, iaddr, iwdata, ibe);
    join
  endtask

  task automatic b_write(input logic [15:0] addr, input logic [15:0] data);
    bit seen;
    seen = 1'b0;
    b_imem_address = addr; b_imem_wdata = data; b_imem_byte_enable = 2'b11;
    b_imem_write = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = b_imem_resp;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL l1_write_timeout: got resp 0 want 1");
    end
    @(posedge clk);
    #1;
    b_imem_write = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pool [8];
    logic [15:0] a, a2;
    int          kind, op, op2;

    reset = 1'b1;
    mem_address = '0; mem_wdata = '0; mem_read = 0; mem_write = 0; mem_byte_enable = '0;
    imem_address = '0; imem_wdata = '0; imem_read = 0; imem_write = 0; imem_byte_enable = '0;
    b_mem_address = '0; b_mem_wdata = '0; b_mem_read = 0; b_mem_write = 0;
    b_mem_byte_enable = '0;
    b_imem_address = '0; b_imem_wdata = '0; b_imem_read = 0; b_imem_write = 0;
    b_imem_byte_enable = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_resp", {15'd0, mem_resp}, 16'h0000);
    check("rst_imem_resp", {15'd0, imem_resp}, 16'h0000);
    check("rst_mem_rdata", mem_rdata, 16'h0000);
    check("rst_imem_rdata", imem_rdata, 16'h0000);
    reset = 1'b0;

    // First tie after reset: data port wins.
    issue2(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11, 1'b0, 1'b1, 16'h0020, 16'h1111, 2'b11);
    // Repeated tie alternates: instruction port first.
    issue2(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);
    issue1(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
    // Partial byte write then readback; be=00 write leaves the word alone.
    issue1(1'b1, 1'b0, 1'b1, 16'h0020, 16'hABCD, 2'b10);
    issue1(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);
    issue1(1'b1, 1'b0, 1'b1, 16'h0020, 16'h5A5A, 2'b00);
    issue1(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);
    // Read and write together act as a write.
    issue1(1'b1, 1'b1, 1'b1, 16'h0030, 16'h5555, 2'b11);
    issue1(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00);
    // Aliased address reaches the same word.
    issue1(1'b0, 1'b1, 1'b0, 16'hE010, 16'h0000, 2'b00);

    // Reset in cycle 1 of a write: the write is dropped and no response appears.
    mem_address = 16'h0010; mem_wdata = 16'hFFFF; mem_byte_enable = 2'b11; mem_write = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_mem_resp", {15'd0, mem_resp}, 16'h0000);
    check("midrst_mem_rdata", mem_rdata, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    mem_write = 1'b0;
    reset = 1'b0;
    m_rd_d = 16'h0000;
    m_rd_i = 16'h0000;
    m_last_d = 1'b0;
    issue1(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);

    // Randomized traffic over a fully initialised address pool.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'h0100 + 16'(2 * i);
      issue1(i[0], 1'b0, 1'b1, pool[i], 16'($urandom), 2'b11);
    end
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      op   = int'($urandom_range(0, 2));
      op2  = int'($urandom_range(0, 2));
      a    = pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 7) << 13);
      a2   = pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 7) << 13);
      if (kind == 2) begin
        issue2(op != 1, op != 0, a, 16'($urandom), 2'($urandom_range(0, 3)),
               op2 != 1, op2 != 0, a2, 16'($urandom), 2'($urandom_range(0, 3)));
      end else begin
        issue1(kind == 1, op != 1, op != 0, a, 16'($urandom), 2'($urandom_range(0, 3)));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("pending_dmem", 16'(q_d_data.size()), 16'h0000);
    check("pending_imem", 16'(q_i_data.size()), 16'h0000);

    // LATENCY=1 instance: instruction read held across two transactions.
    b_write(16'h0000, 16'hC0DE);
    b_write(16'h0002, 16'hBEEF);
    b_imem_address = 16'h0000;
    b_imem_read = 1'b1;
    @(negedge clk);
    check("l1_c0_resp", {15'd0, b_imem_resp}, 16'h0000);
    @(negedge clk);
    check("l1_c1_resp", {15'd0, b_imem_resp}, 16'h0001);
    check("l1_c1_data", b_imem_rdata, 16'hC0DE);
    @(posedge clk);
    #1;
    b_imem_address = 16'h0002;
    @(negedge clk);
    check("l1_c2_resp", {15'd0, b_imem_resp}, 16'h0000);
    @(negedge clk);
    check("l1_c3_resp", {15'd0, b_imem_resp}, 16'h0001);
    check("l1_c3_data", b_imem_rdata, 16'hBEEF);
    @(posedge clk);
    #1;
    b_imem_read = 1'b0;
    @(negedge clk);
    check("l1_c4_resp", {15'd0, b_imem_resp}, 16'h0000);
    check("l1_dmem_resp", {15'd0, b_mem_resp}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
